// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and combinational round helpers.
// Holds the state/byte types, the round count, the round-constant table,
// the FIPS-197 S-box table and the SubBytes/ShiftRows/MixColumns/key-step
// functions. State byte i lives at [127-8*i -: 8]; byte i sits at row i%4,
// column i/4 (column-major).
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    localparam int NR = 10;

    localparam aes_byte_t RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Entry 0 occupies the most significant byte, so SBOX[b] is S(b).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic aes_byte_t xtime(aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t sub_bytes(aes_state_t s);
        aes_state_t o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic aes_state_t shift_rows(aes_state_t s);
        aes_state_t o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = s[127-8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8];
        return o;
    endfunction

    function automatic aes_state_t mix_columns(aes_state_t s);
        aes_state_t o;
        aes_byte_t a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    // sw is SubWord(RotWord(w3)), supplied by the S-box instances.
    function automatic aes_state_t key_step(aes_state_t k, logic [31:0] sw, aes_byte_t rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sw ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_cipher_if.sv
// aes128_cipher_if: start/done handshake and data bus of the AES-128 cipher.
// Ports: start, in_data, key (requester -> cipher); busy, done, out_data
// (cipher -> requester). master = requester side, slave = cipher side.
interface aes128_cipher_if;
    import aes_pkg::*;

    logic       start;
    aes_state_t in_data;
    aes_state_t key;
    logic       busy;
    logic       done;
    aes_state_t out_data;

    modport master (output start, in_data, key, input busy, done, out_data);
    modport slave  (input start, in_data, key, output busy, done, out_data);

endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational FIPS-197 S-box lookup.
// Ports: a (8-bit byte in), y (8-bit substituted byte out).
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t y
);

    assign y = SBOX[a];

endmodule

// File: rtl/aes128_cipher.sv
// aes128_cipher: iterative AES-128 encryptor, one round per clock, key expanded on the fly.
// Ports: clk, rst_n (async active-low), bus (aes128_cipher_if.slave: start,
// in_data, key in; busy, done, out_data out).
// Optional macro CIPHER_ZEROIZE_EN: out_data is cleared when a block is
// accepted and stays 0 until that block's done.
module aes128_cipher
    import aes_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    aes128_cipher_if.slave bus
);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t       fsm_q, fsm_d;
    aes_state_t state_q, state_d;
    aes_state_t rkey_q, rkey_d;
    aes_state_t out_q, out_d;
    logic [3:0] round_q, round_d;
    logic       done_q, done_d;

    aes_state_t  sb;
    logic [31:0] sw;
    aes_state_t  nkey;
    aes_byte_t   rc;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (.a(state_q[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
    end

    // Byte i of RotWord(w3) is byte (i+1)%4 of w3.
    for (genvar i = 0; i < 4; i++) begin : g_word
        aes_sbox u_sbox (.a(rkey_q[31-8*((i+1)%4) -: 8]), .y(sw[31-8*i -: 8]));
    end

    always_comb begin
        rc      = (round_q != 4'd0 && round_q <= 4'(NR)) ? RCON[round_q] : 8'h00;
        nkey    = key_step(rkey_q, sw, rc);
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        round_d = round_q;
        out_d   = out_q;
        done_d  = 1'b0;
        if (fsm_q == IDLE) begin
            if (bus.start) begin
                state_d = bus.in_data ^ bus.key;
                rkey_d  = bus.key;
                round_d = 4'd1;
                fsm_d   = RUN;
`ifdef CIPHER_ZEROIZE_EN
                out_d   = '0;
`endif
            end
        end else if (round_q == 4'(NR)) begin
            out_d   = shift_rows(sb) ^ nkey;
            done_d  = 1'b1;
            round_d = 4'd0;
            fsm_d   = IDLE;
        end else begin
            state_d = mix_columns(shift_rows(sb)) ^ nkey;
            rkey_d  = nkey;
            round_d = round_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            out_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            out_q   <= out_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (fsm_q == RUN);
    assign bus.done     = done_q;
    assign bus.out_data = out_q;

endmodule

// File: tb/tb_aes128_cipher.sv
// tb_aes128_cipher: self-checking bench for aes128_cipher against a transaction-level AES model.
module tb_aes128_cipher;

    localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes128_cipher_if bus();
    aes128_cipher dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    logic cmp_en = 1'b0;
    logic [7:0] sbox_ref [256];

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [127:0] m_out = '0;
    logic [127:0] m_pend = '0;
    int           m_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic hi;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box derived from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, y, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            y = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                y = {y[6:0], y[7]};
                s = s ^ y;
            end
            sbox_ref[a] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] x;
        logic [7:0]  rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            x = w[i-1];
            if (i % 4 == 0) begin
                x = {sbox_ref[x[23:16]], sbox_ref[x[15:8]], sbox_ref[x[7:0]], sbox_ref[x[31:24]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ x;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_ref[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++)
                        s[4*c+j] = gf_mul(t[4*c+j], 8'h02) ^ gf_mul(t[4*c+(j+1)%4], 8'h03)
                                 ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Transaction-level model: accept when idle, result 10 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && bus.start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_pend <= aes_ref(bus.in_data, bus.key);
`ifdef CIPHER_ZEROIZE_EN
                m_out  <= '0;
`endif
            end else if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 9) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out  <= m_pend;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en && rst_n) begin
            chk("busy", 128'(bus.busy), 128'(m_busy));
            chk("done", 128'(bus.done), 128'(m_done));
            chk("out_data", bus.out_data, m_out);
            if (bus.done) n_done++;
        end
    end

    task automatic launch(input logic [127:0] pt, input logic [127:0] k);
        bus.start = 1'b1;
        bus.in_data = pt;
        bus.key = k;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in_data = rnd128();
        bus.key = rnd128();
    endtask

    // Counts edges until done; optionally pulses start (with junk) after edge pulse_at.
    task automatic wait_done(input int pulse_at, output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == pulse_at) begin
                bus.start = 1'b1;
                bus.in_data = rnd128();
                bus.key = rnd128();
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 30 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        bus.start = 1'b0;
        bus.in_data = '0;
        bus.key = '0;
        build_sbox();
        chk("model_c1", aes_ref(C1P, C1K), C1C);
        chk("model_b", aes_ref(BP, BK), BC);
        chk("model_zero", aes_ref('0, '0), ZC);
        #3;
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_done", 128'(bus.done), 128'd0);
        chk("reset_out", bus.out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        launch(C1P, C1K);
        wait_done(2, lat);
        chk("c1_latency", 128'(lat), 128'd10);
        chk("c1_out", bus.out_data, C1C);
        bus.start = 1'b1;
        bus.in_data = BP;
        bus.key = BK;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_accepted", 128'(bus.busy), 128'd1);
        wait_done(0, lat);
        chk("b2b_gap", 128'(lat + 1), 128'd11);
        chk("b_out", bus.out_data, BC);
        @(posedge clk);
        #1;
        chk("b_done_width", 128'(bus.done), 128'd0);
        launch('0, '0);
`ifdef CIPHER_ZEROIZE_EN
        chk("zeroize_out", bus.out_data, 128'd0);
`else
        chk("hold_prev_out", bus.out_data, BC);
`endif
        wait_done(0, lat);
        chk("zero_latency", 128'(lat), 128'd10);
        chk("zero_out", bus.out_data, ZC);
        @(posedge clk);
        #1;
        chk("zero_done_width", 128'(bus.done), 128'd0);
        n0 = n_done;
        repeat (400) begin
            bus.start = ($urandom_range(3) == 0);
            bus.in_data = rnd128();
            bus.key = rnd128();
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        chk("random_blocks", 128'(n_done - n0 >= 15), 128'd1);
        for (int i = 0; i < 20 && m_busy; i++) begin
            @(posedge clk);
            #1;
        end
        launch(C1P, C1K);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(bus.busy), 128'd0);
        chk("abort_done", 128'(bus.done), 128'd0);
        chk("abort_out", bus.out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_done;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_abort", 128'(n_done - n0), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
